// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
// N_CH independent push-button conditioners. Each channel synchronises its
// raw asynchronous input, debounces it with a consecutive-stability counter
// and emits a registered one-cycle pulse on the selected accepted edge(s).
//
// EDGE_MODE: 0 = rising, 1 = falling, 2 = both; any other value acts as 0.
//
// Optional build macro AUTOREPEAT_EN: while a debounced press is held, issue
// a repeat pulse REPEAT_DELAY cycles after the press is accepted and then
// every REPEAT_PERIOD cycles until the release is accepted. Without the
// macro no repeat logic exists and REPEAT_DELAY/REPEAT_PERIOD are unused.
module btn_debounce_pulse #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse
);

    // Debounce counter counts 0 .. DEB_CYCLES-1; the last value triggers acceptance.
    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    // Edge selection; an out-of-range mode falls back to rising-only.
    localparam bit RISE_EN = (EDGE_MODE != 1);
    localparam bit FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);

`ifdef AUTOREPEAT_EN
    // Repeat countdown is wide enough for the larger of the two intervals.
    localparam int            RMAX          = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW            = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_DELAY_LD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_PERIOD_LD = RW'(REPEAT_PERIOD - 1);
`endif

    // Reject configurations the datapath cannot represent.
    if (N_CH < 1 || SYNC_STAGES < 2 || DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_param
        $error("btn_debounce_pulse: parameter out of range");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic [CW-1:0]          cnt_q;
        logic [CW-1:0]          cnt_d;
        logic                   accept;
        logic                   level_q;
        logic                   pulse_d;
        logic                   pulse_q;
        logic                   rep_fire;

        // Shift the raw button through the synchroniser chain; only the last stage is used.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                // NOTE: non-blocking so every flop samples the pre-edge value regardless of statement order.
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn[ch]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Count consecutive cycles the synchronised input disagrees with level; any agreement restarts it.
        always_comb begin
            // NOTE: defaults first so every path assigns cnt_d and accept and no latch is inferred.
            cnt_d  = '0;
            accept = 1'b0;
            if (s != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Debounce state: stability counter and the accepted level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                if (accept) begin
                    level_q <= s;
                end
            end
        end

`ifdef AUTOREPEAT_EN
        logic [RW-1:0] rep_q;

        // A repeat is due while the press is held and the countdown has reached zero;
        // an accepted release in the same cycle wins.
        assign rep_fire = level_q && !accept && (rep_q == '0);

        // Repeat countdown: loaded on a rising accept, reloaded after each repeat, held at zero while released.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_q <= '0;
            end else if (accept && !level_q) begin
                rep_q <= REP_DELAY_LD;
            end else if (accept || !level_q) begin
                rep_q <= '0;
            end else if (rep_q == '0) begin
                rep_q <= REP_PERIOD_LD;
            end else begin
                rep_q <= rep_q - RW'(1);
            end
        end
`else
        assign rep_fire = 1'b0;
`endif

        // Pulse on an accepted edge of an enabled polarity, or on a due repeat in rising modes.
        always_comb begin
            pulse_d = 1'b0;
            if (accept) begin
                pulse_d = s ? RISE_EN : FALL_EN;
            end
            if (rep_fire && RISE_EN) begin
                pulse_d = 1'b1;
            end
        end

        // Register the strobe so it lines up with the first cycle of the new level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= pulse_d;
            end
        end

        assign level[ch] = level_q;
        assign pulse[ch] = pulse_q;
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Testbench for btn_debounce_pulse: four instances (EDGE_MODE 0..3) share one
// button bus. A window-based reference model is compared every cycle, plus a
// vector table and hand-written sequences for the timing corner cases.
module tb_btn_debounce_pulse;

    localparam int N_CH    = 2;
    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int RDLY    = 10;
    localparam int RPER    = 5;
    localparam int N_MODES = 4;
    localparam int LAT     = SYNC + DEB;
    localparam int HLEN    = SYNC + DEB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] dut_level [N_MODES];
    logic [N_CH-1:0] dut_pulse [N_MODES];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < N_MODES; m++) begin : g_dut
        btn_debounce_pulse #(
            .N_CH          (N_CH),
            .SYNC_STAGES   (SYNC),
            .DEB_CYCLES    (DEB),
            .EDGE_MODE     (m),
            .REPEAT_DELAY  (RDLY),
            .REPEAT_PERIOD (RPER)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn),
            .level (dut_level[m]),
            .pulse (dut_pulse[m])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[0] is the newest sampled btn. A channel flips when the DEB
    // synchronised samples seen by the logic all disagree with its level.
    logic [HLEN-1:0][N_CH-1:0]    hist;
    logic [N_CH-1:0]              m_level;
    logic [N_MODES-1:0][N_CH-1:0] m_pulse;
    int                           held [N_CH];

    function automatic bit rise_en(int mode);
        return mode != 1;
    endfunction

    function automatic bit fall_en(int mode);
        return (mode == 1) || (mode == 2);
    endfunction

    function automatic bit repeat_due(int n);
`ifdef AUTOREPEAT_EN
        return (n >= RDLY) && (((n - RDLY) % RPER) == 0);
`else
        return n < 0;
`endif
    endfunction

    function automatic bit window_flips(int ch);
        for (int j = SYNC - 1; j <= SYNC + DEB - 2; j++) begin
            if (hist[j][ch] == m_level[ch]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : ref_model
        if (!rst_n) begin
            hist    <= '0;
            m_level <= '0;
            m_pulse <= '0;
            for (int ch = 0; ch < N_CH; ch++) held[ch] <= 0;
        end else begin
            hist <= {hist[HLEN-2:0], btn};
            for (int ch = 0; ch < N_CH; ch++) begin
                if (window_flips(ch)) begin
                    m_level[ch] <= ~m_level[ch];
                    held[ch]    <= 0;
                    for (int m = 0; m < N_MODES; m++)
                        m_pulse[m][ch] <= m_level[ch] ? fall_en(m) : rise_en(m);
                end else begin
                    held[ch] <= m_level[ch] ? held[ch] + 1 : 0;
                    for (int m = 0; m < N_MODES; m++)
                        m_pulse[m][ch] <= m_level[ch] && rise_en(m) && repeat_due(held[ch] + 1);
                end
            end
        end
    end

    always @(negedge clk) begin : ref_check
        if (chk_en) begin
            for (int m = 0; m < N_MODES; m++) begin
                check($sformatf("model level mode%0d", m), dut_level[m], m_level);
                check($sformatf("model pulse mode%0d", m), dut_pulse[m], m_pulse[m]);
            end
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [N_CH-1:0] btn;
        int              hold;
        logic [N_CH-1:0] exp_level;
        int              exp_rise;
        int              exp_fall;
        int              exp_both;
    } vec_t;

    vec_t vecs [10];

    function automatic int exp_for_mode(vec_t v, int m);
        if (m == 1) return v.exp_fall;
        if (m == 2) return v.exp_both;
        return v.exp_rise;
    endfunction

    task automatic settle_idle();
        @(negedge clk);
        btn = '0;
        repeat (3 * LAT) @(posedge clk);
    endtask

    // Drive a value at the falling edge, then check level and pulse of mode 0
    // for LAT+2 rising edges: level flips and pulse strobes exactly at edge LAT.
    task automatic press_and_check(input string name, input logic [N_CH-1:0] val);
        @(negedge clk);
        btn = val;
        for (int i = 1; i <= LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s level e%0d", name, i), dut_level[0], (i >= LAT) ? val : '0);
            check($sformatf("%s pulse e%0d", name, i), dut_pulse[0], (i == LAT) ? val : '0);
        end
    endtask

    int cnt [N_MODES];
    int bounce_seq [5] = '{1, 0, 1, 1, 0};

    initial begin
        rst_n = 1'b1;
        btn   = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;

        vecs = '{
            '{2'b00, 8, 2'b00, 0, 0, 0},
            '{2'b01, 8, 2'b01, 1, 0, 1},
            '{2'b10, 8, 2'b10, 1, 1, 2},
            '{2'b00, 8, 2'b00, 0, 1, 1},
            '{2'b11, 8, 2'b11, 2, 0, 2},
            '{2'b00, 8, 2'b00, 0, 2, 2},
            '{2'b01, 3, 2'b00, 0, 0, 0},
            '{2'b00, 8, 2'b00, 0, 0, 0},
            '{2'b01, 8, 2'b01, 1, 0, 1},
            '{2'b00, 8, 2'b00, 0, 1, 1}
        };

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < N_MODES; m++) begin
            check($sformatf("reset level mode%0d", m), dut_level[m], 2'b00);
            check($sformatf("reset pulse mode%0d", m), dut_pulse[m], 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Vector table: per-vector pulse counts for every mode plus final level
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            btn = vecs[v].btn;
            for (int m = 0; m < N_MODES; m++) cnt[m] = 0;
            for (int i = 0; i < vecs[v].hold; i++) begin
                @(posedge clk);
                #1;
                for (int m = 0; m < N_MODES; m++) cnt[m] += $countones(dut_pulse[m]);
            end
            check($sformatf("vec%0d level", v), dut_level[0], vecs[v].exp_level);
            for (int m = 0; m < N_MODES; m++)
                check($sformatf("vec%0d pulses mode%0d", v, m), cnt[m], exp_for_mode(vecs[v], m));
        end
        settle_idle();

        // Clean press on channel 0: pulse and level exactly LAT edges later
        press_and_check("clean press", 2'b01);
        settle_idle();

        // Bounce 1,0,1,1,0 then steady 1: no pulse until LAT after the last rise
        cnt[0] = 0;
        foreach (bounce_seq[i]) begin
            @(negedge clk);
            btn = (bounce_seq[i] != 0) ? 2'b01 : 2'b00;
            @(posedge clk);
            #1;
            cnt[0] += $countones(dut_pulse[0]);
        end
        check("bounce no pulse", cnt[0], 0);
        press_and_check("bounce settle", 2'b01);
        settle_idle();

        // Press then release channel 1, each held 10 cycles
        for (int m = 0; m < N_MODES; m++) cnt[m] = 0;
        @(negedge clk);
        btn = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < N_MODES; m++) cnt[m] += $countones(dut_pulse[m]);
        end
        @(negedge clk);
        btn = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < N_MODES; m++) cnt[m] += $countones(dut_pulse[m]);
        end
        check("press/release rise", cnt[0], 1);
        check("press/release fall", cnt[1], 1);
        check("press/release both", cnt[2], 2);
        check("press/release illegal mode", cnt[3], 1);
        settle_idle();

        // Simultaneous rise on both channels, then a 100-cycle hold
        press_and_check("dual press", 2'b11);
        cnt[0] = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (dut_pulse[0] != '0) cnt[0]++;
        end
`ifdef AUTOREPEAT_EN
        check("dual hold repeat cycles", cnt[0], 19);
`else
        check("dual hold no extra pulse", cnt[0], 0);
`endif
        settle_idle();

        // Reset while the debounce count is at 2 with the button still pressed
        @(negedge clk);
        btn = 2'b01;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("in-reset level c%0d", i), dut_level[0], 2'b00);
            check($sformatf("in-reset pulse c%0d", i), dut_pulse[0], 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset level e%0d", i), dut_level[0], (i >= LAT) ? 2'b01 : 2'b00);
            check($sformatf("post-reset pulse e%0d", i), dut_pulse[0], (i == LAT) ? 2'b01 : 2'b00);
        end
        settle_idle();

        // Long hold on channel 0 (40 cycles past accept), then release
        for (int m = 0; m < N_MODES; m++) cnt[m] = 0;
        @(negedge clk);
        btn = 2'b01;
        for (int i = 0; i < LAT + 40; i++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < N_MODES; m++) cnt[m] += $countones(dut_pulse[m]);
        end
        @(negedge clk);
        btn = 2'b00;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < N_MODES; m++) cnt[m] += $countones(dut_pulse[m]);
        end
`ifdef AUTOREPEAT_EN
        check("long hold rise", cnt[0], 9);
        check("long hold both", cnt[2], 10);
        check("long hold illegal mode", cnt[3], 9);
`else
        check("long hold rise", cnt[0], 1);
        check("long hold both", cnt[2], 2);
        check("long hold illegal mode", cnt[3], 1);
`endif
        check("long hold fall", cnt[1], 1);
        settle_idle();

        // Random stimulus with occasional resets, checked by the model every cycle
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            btn   = N_CH'($urandom);
            rst_n = ($urandom_range(0, 39) != 0);
            repeat ($urandom_range(1, 8)) @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
Multi-channel successor to the single-button one-pulse generator. Each channel synchronises an asynchronous push-button input and debounces it with a per-channel stability counter. It then emits a one-cycle pulse on the selected debounced edge(s). It sits between the board buttons and the control FSMs (e.g. operand/opcode load strobes).

Parameters:
N_CH, 4, number of independent button channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEB_CYCLES, 16, consecutive stable cycles required to accept a new level (>=1; 1 = no filtering)
EDGE_MODE, 0, pulse source: 0 = rising, 1 = falling, 2 = both edges
REPEAT_DELAY, 1000, cycles a debounced press must be held before the first repeat pulse (AUTOREPEAT_EN only, >=1)
REPEAT_PERIOD, 200, cycles between subsequent repeat pulses (AUTOREPEAT_EN only, >=1)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
btn  in  N_CH  raw asynchronous button inputs, active-high
level  out  N_CH  debounced, registered button level per channel
pulse  out  N_CH  one-cycle strobe per channel per EDGE_MODE (plus repeats when enabled)

Behaviour:
- Reset (rst_n low, asynchronous assert): synchroniser flops, level, pulse, debounce counters and repeat counters all clear to 0. Release is sampled on clk. No pulse is ever produced by reset assertion or release.
- Synchroniser: per channel, SYNC_STAGES-deep shift chain. s = last stage. Only s feeds the logic; no combinational path from btn.
- Debounce, per channel, counter cnt of width clog2(DEB_CYCLES+1):
  - s == level: cnt <= 0.
  - s != level and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - s != level and cnt == DEB_CYCLES-1: level <= s, cnt <= 0 (accept event).
- Any glitch back to level before acceptance restarts the count from 0. The count is consecutive, not cumulative.
- Latency: a clean btn transition appears on level SYNC_STAGES+DEB_CYCLES rising edges after it is first sampled.
- pulse is registered and asserted in the same cycle level first shows the new value, for exactly one cycle:
  - Rising accept: pulse = 1 if EDGE_MODE is 0 or 2.
  - Falling accept: pulse = 1 if EDGE_MODE is 1 or 2.
- Channels are fully independent. Simultaneous accepts on several channels produce simultaneous pulses.
- A button held indefinitely gives exactly one pulse (without AUTOREPEAT_EN). Re-arming needs an accepted opposite level.
- Illegal EDGE_MODE (>2) behaves as 0.
- Reset mid-debounce discards partial counts. The first post-reset accept follows the normal rules.

Optional Feature:
Macro AUTOREPEAT_EN.
- Defined: each channel has a repeat counter, cleared whenever level == 0.
  - After a rising accept, when level has been 1 for REPEAT_DELAY cycles, pulse asserts for one cycle (if EDGE_MODE is 0 or 2).
  - Thereafter a pulse is issued every REPEAT_PERIOD cycles while level stays 1.
  - A falling accept stops repeats immediately. The counter is saturating/reloading, so it never wraps into a spurious pulse.
- Undefined: no repeat counters are synthesised. REPEAT_DELAY and REPEAT_PERIOD are ignored; behaviour is exactly as described in Behaviour.

Test Plan:
- N_CH=2, SYNC_STAGES=2, DEB_CYCLES=4, EDGE_MODE=0; btn[0] 0->1 clean at edge k -> level[0]=1 and pulse[0]=1 for exactly one cycle after edge k+6; level[1], pulse[1] stay 0.
- Same config; btn[0] bounces 1,0,1,1,0 (one cycle each), then steady 1 -> no pulse during bounce; single pulse 6 edges after the last 0->1.
- EDGE_MODE=2; press then release btn[1] (each held 10 cycles) -> exactly two one-cycle pulses, one on each accepted edge; EDGE_MODE=1 gives only the release pulse.
- btn[0] and btn[1] rise on the same cycle -> pulse = 2'b11 on the same cycle; btn held 100 cycles -> no further pulses.
- rst_n low for 3 cycles while cnt = 2 with btn held 1; release with btn still 1 -> level = 0 during reset; accept and single pulse SYNC_STAGES+DEB_CYCLES edges after release; no pulse at reset edges.
- AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold btn[0] for 40 cycles after accept -> pulses at accept, accept+10, +15, +20, ... until the falling accept; none afterwards.
